// File: rtl/lcd_scene_arbiter_pkg.sv
// Shared definitions for the LCD scene arbiter: default widths, scene codes, FSM encoding.
package lcd_scene_arbiter_pkg;

    localparam int SCENE_W_DEF = 3;

    localparam int SCENE_IDLE_A = 0;
    localparam int SCENE_IDLE_B = 1;
    localparam int SCENE_STATUS = 2;
    localparam int SCENE_ALARM  = 3;
    localparam int SCENE_BUTTON = 4;
    localparam int SCENE_FEED   = 5;
    localparam int SCENE_SLEEP  = 6;
    localparam int SCENE_ERROR  = 7;

    typedef enum logic [1:0] {
        S_POWERUP = 2'd0,
        S_IDLE    = 2'd1,
        S_GRANT   = 2'd2
    } arb_state_t;

endpackage

// File: rtl/lcd_scene_arbiter_if.sv
// Bundle between the game-logic requesters and the scene arbiter / LCD driver side.
interface lcd_scene_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int SCENE_W = 3
);
    logic [NUM_REQ-1:0]         req_i;
    logic [NUM_REQ*SCENE_W-1:0] scene_req_i;
    logic                       ready_o;
    logic [SCENE_W-1:0]         scene_o;
    logic [NUM_REQ-1:0]         grant_o;
    logic                       tick_o;

    // Game logic side: raises requests, observes grant and the displayed scene.
    modport master (
        output req_i,
        output scene_req_i,
        input  ready_o,
        input  scene_o,
        input  grant_o,
        input  tick_o
    );

    // Arbiter side: consumes requests, drives the LCD driver controls.
    modport slave (
        input  req_i,
        input  scene_req_i,
        output ready_o,
        output scene_o,
        output grant_o,
        output tick_o
    );
endinterface

// File: rtl/lcd_scene_arbiter_tick_gen.sv
// Prescaler producing the scheduling tick: one cycle high every TICK_DIV clocks.
module lcd_tick_gen #(
    parameter int TICK_DIV = 800000
) (
    input  logic clk,
    input  logic reset,
    output logic tick_o
);
    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] div_cnt;

    // The tick is decoded straight off the counter, so with TICK_DIV=1 it is always high.
    assign tick_o = (div_cnt == DIV_LAST);

    // Free-running divider that wraps on the tick cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            div_cnt <= '0;
        end else if (tick_o) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end
endmodule

// File: rtl/lcd_scene_arbiter.sv
// Fixed-priority scene scheduler in front of the LCD1602 custom-character driver.
// Handles power-up wait, minimum scene hold and a two-scene idle animation.
module lcd_scene_arbiter
    import lcd_scene_arbiter_pkg::*;
#(
    parameter int NUM_REQ       = 4,
    parameter int SCENE_W       = SCENE_W_DEF,
    parameter int TICK_DIV      = 800000,
    parameter int POWERUP_TICKS = 4,
    parameter int MIN_HOLD      = 8,
    parameter int ANIM_PERIOD   = 32,
    parameter logic [SCENE_W-1:0] IDLE_SCENE_A = SCENE_W'(SCENE_IDLE_A),
    parameter logic [SCENE_W-1:0] IDLE_SCENE_B = SCENE_W'(SCENE_IDLE_B)
) (
    input logic             clk,
    input logic             reset,
    lcd_scene_arbiter_if.slave bus
);
    localparam int OWN_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int PWR_W  = $clog2(POWERUP_TICKS + 1);
    localparam int HOLD_W = $clog2(MIN_HOLD + 1);
    localparam int ANIM_W = $clog2(ANIM_PERIOD + 1);

    localparam logic [PWR_W-1:0]  PWR_LAST    = PWR_W'(POWERUP_TICKS - 1);
    localparam logic [HOLD_W-1:0] HOLD_RELOAD = HOLD_W'(MIN_HOLD - 1);
    localparam logic [ANIM_W-1:0] ANIM_LAST   = ANIM_W'(ANIM_PERIOD - 1);

    arb_state_t         state;
    logic [PWR_W-1:0]   pwr_cnt;
    logic [HOLD_W-1:0]  hold_cnt;
    logic [ANIM_W-1:0]  anim_cnt;
    logic [OWN_W-1:0]   owner;
    logic               ready_r;
    logic [SCENE_W-1:0] scene_r;
    logic [NUM_REQ-1:0] grant_r;

    logic               tick;
    logic               any_req;
    logic [OWN_W-1:0]   low_idx;
    logic [SCENE_W-1:0] low_scene;
    logic [SCENE_W-1:0] owner_scene;
    logic               owner_req;

    // Lowest set request index wins; returns 0 when nothing is set (callers gate on any_req).
    function automatic logic [OWN_W-1:0] lowest_index(input logic [NUM_REQ-1:0] r);
        lowest_index = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (r[k]) lowest_index = OWN_W'(k);
        end
    endfunction

    lcd_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clk    (clk),
        .reset  (reset),
        .tick_o (tick)
    );

    assign any_req     = |bus.req_i;
    assign low_idx     = lowest_index(bus.req_i);
    assign low_scene   = bus.scene_req_i[int'(low_idx) * SCENE_W +: SCENE_W];
    assign owner_scene = bus.scene_req_i[int'(owner) * SCENE_W +: SCENE_W];
    assign owner_req   = bus.req_i[owner];

    assign bus.tick_o  = tick;
    assign bus.ready_o = ready_r;
    assign bus.scene_o = scene_r;
    assign bus.grant_o = grant_r;

    // Scheduler FSM: everything advances only on scheduling ticks, outputs are registered.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_POWERUP;
            pwr_cnt  <= '0;
            hold_cnt <= '0;
            anim_cnt <= '0;
            owner    <= '0;
            ready_r  <= 1'b0;
            scene_r  <= IDLE_SCENE_A;
            grant_r  <= '0;
        end else if (tick) begin
            case (state)
                S_POWERUP: begin
                    if (pwr_cnt == PWR_LAST) begin
                        ready_r <= 1'b1;
                        state   <= S_IDLE;
                    end else begin
                        pwr_cnt <= pwr_cnt + 1'b1;
                    end
                end

                S_IDLE: begin
                    if (any_req) begin
                        owner    <= low_idx;
                        grant_r  <= NUM_REQ'(1) << low_idx;
                        scene_r  <= low_scene;
                        hold_cnt <= HOLD_RELOAD;
                        state    <= S_GRANT;
                    end else if (anim_cnt == ANIM_LAST) begin
                        anim_cnt <= '0;
                        scene_r  <= (scene_r == IDLE_SCENE_A) ? IDLE_SCENE_B : IDLE_SCENE_A;
                    end else begin
                        anim_cnt <= anim_cnt + 1'b1;
                    end
                end

                S_GRANT: begin
                    if (hold_cnt != '0) begin
                        hold_cnt <= hold_cnt - 1'b1;
                    end else if (any_req && (low_idx < owner)) begin
                        owner    <= low_idx;
                        grant_r  <= NUM_REQ'(1) << low_idx;
                        scene_r  <= low_scene;
                        hold_cnt <= HOLD_RELOAD;
                    end else if (owner_req) begin
                        if (owner_scene != scene_r) begin
                            scene_r  <= owner_scene;
                            hold_cnt <= HOLD_RELOAD;
                        end
                    end else if (any_req) begin
                        owner    <= low_idx;
                        grant_r  <= NUM_REQ'(1) << low_idx;
                        scene_r  <= low_scene;
                        hold_cnt <= HOLD_RELOAD;
                    end else begin
                        grant_r  <= '0;
                        scene_r  <= IDLE_SCENE_A;
                        anim_cnt <= '0;
                        state    <= S_IDLE;
                    end
                end

                default: begin
                    state <= S_POWERUP;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_lcd_scene_arbiter.sv
// Randomized scoreboard bench for lcd_scene_arbiter with a tick-level reference model.
module tb_lcd_scene_arbiter;
    localparam int NUM_REQ       = 4;
    localparam int SCENE_W       = 3;
    localparam int TICK_DIV      = 4;
    localparam int POWERUP_TICKS = 2;
    localparam int MIN_HOLD      = 3;
    localparam int ANIM_PERIOD   = 4;
    localparam int SCN_A         = 0;
    localparam int SCN_B         = 1;

    typedef struct {
        logic               ready;
        logic [SCENE_W-1:0] scene;
        logic [NUM_REQ-1:0] grant;
    } exp_t;

    logic clk;
    logic reset;

    lcd_scene_arbiter_if #(.NUM_REQ(NUM_REQ), .SCENE_W(SCENE_W)) bus ();

    lcd_scene_arbiter #(
        .NUM_REQ       (NUM_REQ),
        .SCENE_W       (SCENE_W),
        .TICK_DIV      (TICK_DIV),
        .POWERUP_TICKS (POWERUP_TICKS),
        .MIN_HOLD      (MIN_HOLD),
        .ANIM_PERIOD   (ANIM_PERIOD),
        .IDLE_SCENE_A  (3'(SCN_A)),
        .IDLE_SCENE_B  (3'(SCN_B))
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int   checks = 0;
    int   errors = 0;
    exp_t expq[$];

    // Reference model state: mode 0 = powering up, 1 = idle, 2 = scene owned.
    int                 m_mode;
    int                 m_pwr_ticks;
    int                 m_idle_ticks;
    int                 m_age;
    int                 m_owner;
    logic               m_ready;
    logic [SCENE_W-1:0] m_scene;
    logic [NUM_REQ-1:0] m_grant;
    int                 cyc;
    bit                 started = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic int lowest_set(input logic [NUM_REQ-1:0] r);
        for (int k = 0; k < NUM_REQ; k++) if (r[k]) return k;
        return -1;
    endfunction

    function automatic logic [SCENE_W-1:0] scene_of(input logic [NUM_REQ*SCENE_W-1:0] s, input int k);
        return s[k*SCENE_W +: SCENE_W];
    endfunction

    task automatic model_grant(input logic [NUM_REQ*SCENE_W-1:0] s, input int k);
        m_owner = k;
        m_grant = NUM_REQ'(1) << k;
        m_scene = scene_of(s, k);
        m_age   = 0;
        m_mode  = 2;
    endtask

    task automatic model_reset();
        m_mode = 0; m_pwr_ticks = 0; m_idle_ticks = 0; m_age = 0; m_owner = 0;
        m_ready = 1'b0; m_scene = 3'(SCN_A); m_grant = '0;
    endtask

    // One scheduling tick of the rules, written in terms of ticks elapsed since each event.
    task automatic model_tick(input logic [NUM_REQ-1:0] r, input logic [NUM_REQ*SCENE_W-1:0] s);
        int low;
        low = lowest_set(r);
        case (m_mode)
            0: begin
                m_pwr_ticks++;
                if (m_pwr_ticks == POWERUP_TICKS) begin
                    m_ready = 1'b1;
                    m_mode = 1;
                    m_idle_ticks = 0;
                end
            end
            1: begin
                if (low >= 0) begin
                    model_grant(s, low);
                end else begin
                    m_idle_ticks++;
                    m_scene = (((m_idle_ticks / ANIM_PERIOD) % 2) == 1) ? 3'(SCN_B) : 3'(SCN_A);
                end
            end
            default: begin
                m_age++;
                if (m_age >= MIN_HOLD) begin
                    if (low >= 0 && low < m_owner) begin
                        model_grant(s, low);
                    end else if (r[m_owner]) begin
                        if (scene_of(s, m_owner) != m_scene) begin
                            m_scene = scene_of(s, m_owner);
                            m_age = 0;
                        end
                    end else if (low >= 0) begin
                        model_grant(s, low);
                    end else begin
                        m_mode = 1;
                        m_grant = '0;
                        m_scene = 3'(SCN_A);
                        m_idle_ticks = 0;
                    end
                end
            end
        endcase
    endtask

    // Scoreboard producer: runs the model on the same edges the DUT samples and queues the expectation.
    always @(posedge clk) begin
        exp_t e;
        bit   tk;
        if (reset) begin
            started = 1;
            cyc = 0;
            model_reset();
            e.ready = m_ready; e.scene = m_scene; e.grant = m_grant;
            expq.push_back(e);
        end else if (started) begin
            tk = (cyc == TICK_DIV - 1);
            cyc = tk ? 0 : cyc + 1;
            if (tk) begin
                model_tick(bus.req_i, bus.scene_req_i);
                e.ready = m_ready; e.scene = m_scene; e.grant = m_grant;
                expq.push_back(e);
            end
        end
    end

    // Monitor: checks the tick strobe every cycle and pops one expectation per registered update.
    always @(negedge clk) begin
        exp_t e;
        if (started) begin
            checkOutput("tick_o", 32'(bus.tick_o), 32'(cyc == TICK_DIV - 1));
            if (expq.size() > 0) begin
                e = expq.pop_front();
                checkOutput("ready_o", 32'(bus.ready_o), 32'(e.ready));
                checkOutput("scene_o", 32'(bus.scene_o), 32'(e.scene));
                checkOutput("grant_o", 32'(bus.grant_o), 32'(e.grant));
            end
        end
    end

    task automatic applyStimulus(input logic [NUM_REQ-1:0] r, input logic [NUM_REQ*SCENE_W-1:0] s,
                                 input int cycles);
        bus.req_i = r;
        bus.scene_req_i = s;
        repeat (cycles) @(negedge clk);
    endtask

    task automatic pulse_reset(input int cycles);
        reset = 1'b1;
        repeat (cycles) @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        logic [NUM_REQ-1:0]         r;
        logic [NUM_REQ*SCENE_W-1:0] s;
        reset = 1'b1;
        bus.req_i = '0;
        bus.scene_req_i = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        $display("[TB] power-up and idle animation");
        applyStimulus(4'b0000, 12'h000, TICK_DIV * 20);

        $display("[TB] single requester, then higher priority arrives during hold");
        applyStimulus(4'b0100, 12'(5) << 6, TICK_DIV * 6);
        applyStimulus(4'b0101, (12'(5) << 6) | 12'(3), TICK_DIV * 8);
        applyStimulus(4'b0000, 12'h000, TICK_DIV * 6);

        $display("[TB] owner drops early");
        applyStimulus(4'b0100, 12'(5) << 6, TICK_DIV);
        applyStimulus(4'b0000, 12'h000, TICK_DIV * 12);

        $display("[TB] simultaneous requests");
        applyStimulus(4'b1010, (12'(6) << 9) | (12'(2) << 3), TICK_DIV * 6);
        applyStimulus(4'b1000, 12'(6) << 9, TICK_DIV * 6);
        applyStimulus(4'b1000, 12'(4) << 9, TICK_DIV * 6);
        applyStimulus(4'b0000, 12'h000, TICK_DIV * 3);

        $display("[TB] reset while granted");
        applyStimulus(4'b0100, 12'(5) << 6, TICK_DIV * 3);
        pulse_reset(2);
        applyStimulus(4'b0100, 12'(5) << 6, TICK_DIV * 6);

        $display("[TB] randomized traffic");
        for (int i = 0; i < 250; i++) begin
            r = NUM_REQ'($urandom & $urandom);
            s = 12'($urandom);
            if ($urandom_range(0, 80) == 0) pulse_reset($urandom_range(1, 3));
            applyStimulus(r, s, $urandom_range(1, 12));
        end

        applyStimulus(4'b0000, 12'h000, 3);
        checkOutput("queue_drain", 32'(expq.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
